// File: rtl/mc_bus_if.sv
// MCU asynchronous parallel bus between an MCU (master) and mc_bus_slave.
// The bidirectional data pin is carried as inbound data, outbound data and an output enable.
interface mc_bus_if #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6
);
  logic                     mc_ce;
  logic                     mc_we;
  logic                     mc_oe;
  logic [MC_ADD_WIDTH-1:0]  mc_add;
  logic [MC_DATA_WIDTH-1:0] mc_data_in;
  logic [MC_DATA_WIDTH-1:0] mc_data_out;
  logic                     mc_data_oe;

  modport master (
    output mc_ce, mc_we, mc_oe, mc_add, mc_data_in,
    input  mc_data_out, mc_data_oe
  );

  modport slave (
    input  mc_ce, mc_we, mc_oe, mc_add, mc_data_in,
    output mc_data_out, mc_data_oe
  );
endinterface

// File: rtl/mc_bus_slave.sv
// MCU asynchronous-bus register slave with a FIFO read port and a status word.
// Optional feature: define MC_READBACK_EN to make writable slots readable over the bus.
module mc_bus_slave #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int NUM_REGS      = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  mc_bus_if.slave                           bus,
  output logic [NUM_REGS*MC_DATA_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]               wr_strobe_o,
  input  logic [MC_DATA_WIDTH-1:0]          fifo_rd_data_i,
  input  logic                              fifo_empty_i,
  output logic                              fifo_rd_en_o
);

  localparam int DW = MC_DATA_WIDTH;
  localparam logic [MC_ADD_WIDTH-1:0] FIFO_ADDR   = MC_ADD_WIDTH'(2);
  localparam logic [MC_ADD_WIDTH-1:0] STATUS_ADDR = MC_ADD_WIDTH'(NUM_REGS - 1);

  // Slot 2 is the FIFO port and the top slot is status; neither holds bus-written data.
  function automatic logic slot_writable(input int k);
    return (k != 2) && (k != (NUM_REGS - 1));
  endfunction

  // strobe chains: [0] first flop, [1] synchronized level, [2] edge-detect stage
  logic [2:0] ce_sync_q, we_sync_q, oe_sync_q;
  logic       ce_s, we_s, oe_s;
  logic       ce_rise_s, we_rise_s, oe_rise_s, oe_fall_s;

  logic [MC_ADD_WIDTH-1:0] hold_add_q, hold_add_d;
  logic [DW-1:0]           hold_data_q, hold_data_d;
  logic                    wr_pending_q, wr_pending_d;
  logic                    commit_s;
  logic [NUM_REGS*DW-1:0]  regs_q, regs_d;
  logic [NUM_REGS-1:0]     wr_strobe_q, wr_strobe_d;

  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [DW-1:0] slot_rd_s, status_s, rd_mux_s;
  logic          underflow_q, underflow_d;
  logic          fifo_rd_en_q, fifo_rd_en_d;
  logic          fifo_access_s;

  // Bus strobe synchronizers; idle level is high so reset cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_sync_q <= 3'b111;
      we_sync_q <= 3'b111;
      oe_sync_q <= 3'b111;
    end else begin
      ce_sync_q <= {ce_sync_q[1:0], bus.mc_ce};
      we_sync_q <= {we_sync_q[1:0], bus.mc_we};
      oe_sync_q <= {oe_sync_q[1:0], bus.mc_oe};
    end
  end

  assign ce_s      = ce_sync_q[1];
  assign we_s      = we_sync_q[1];
  assign oe_s      = oe_sync_q[1];
  assign ce_rise_s = ce_sync_q[1] & ~ce_sync_q[2];
  assign we_rise_s = we_sync_q[1] & ~we_sync_q[2];
  assign oe_rise_s = oe_sync_q[1] & ~oe_sync_q[2];
  assign oe_fall_s = ~oe_sync_q[1] & oe_sync_q[2];

  // Capture address/data during a write and track whether it is still eligible to commit.
  always_comb begin
    hold_add_d   = hold_add_q;
    hold_data_d  = hold_data_q;
    wr_pending_d = wr_pending_q;
    if (!we_s && !ce_s) begin
      hold_add_d   = bus.mc_add;
      hold_data_d  = bus.mc_data_in;
      wr_pending_d = 1'b1;
    end else if (we_rise_s || ce_rise_s) begin
      wr_pending_d = 1'b0;
    end else begin
      wr_pending_d = wr_pending_q;
    end
  end

  // a chip-enable release before the write strobe rises drops the pending write
  assign commit_s = we_rise_s && !ce_s && wr_pending_q;

  // Commit the held word into its slot and raise that slot's strobe for one cycle.
  always_comb begin
    regs_d      = regs_q;
    wr_strobe_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (commit_s && slot_writable(k) && (hold_add_q == MC_ADD_WIDTH'(k))) begin
        regs_d[k*DW +: DW] = hold_data_q;
        wr_strobe_d[k]     = 1'b1;
      end else begin
        wr_strobe_d[k]     = 1'b0;
      end
    end
  end

  assign status_s = {{(DW-2){1'b0}}, underflow_q, fifo_empty_i};

  // Writable-slot read value; zero unless readback is built in.
  always_comb begin
    slot_rd_s = '0;
`ifdef MC_READBACK_EN
    for (int k = 0; k < NUM_REGS; k++) begin
      slot_rd_s = slot_rd_s |
                  ((slot_writable(k) && (bus.mc_add == MC_ADD_WIDTH'(k))) ?
                   regs_q[k*DW +: DW] : {DW{1'b0}});
    end
`else
    slot_rd_s = {DW{1'b0}};
`endif
  end

  // Address mux; out-of-range addresses fall through to a zero slot value.
  always_comb begin
    if (bus.mc_add == FIFO_ADDR) begin
      rd_mux_s = fifo_empty_i ? {DW{1'b0}} : fifo_rd_data_i;
    end else if (bus.mc_add == STATUS_ADDR) begin
      rd_mux_s = status_s;
    end else begin
      rd_mux_s = slot_rd_s;
    end
  end

  // a concurrent write (we low) suppresses the FIFO side effects of the read
  assign fifo_access_s = oe_fall_s && !ce_s && we_s && (bus.mc_add == FIFO_ADDR);

  // Read data tracks while oe is idle, freezes on oe fall, pops the FIFO once per pulse.
  always_comb begin
    rd_data_d    = rd_data_q;
    underflow_d  = underflow_q;
    fifo_rd_en_d = 1'b0;
    if (oe_s) begin
      rd_data_d = rd_mux_s;
      if (oe_rise_s && (bus.mc_add == STATUS_ADDR)) begin
        underflow_d = 1'b0;
      end else begin
        underflow_d = underflow_q;
      end
    end else if (fifo_access_s) begin
      if (fifo_empty_i) begin
        rd_data_d   = {DW{1'b0}};
        underflow_d = 1'b1;
      end else begin
        rd_data_d    = fifo_rd_data_i;
        fifo_rd_en_d = 1'b1;
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_add_q   <= '0;
      hold_data_q  <= '0;
      wr_pending_q <= 1'b0;
      regs_q       <= '0;
      wr_strobe_q  <= '0;
      rd_data_q    <= '0;
      underflow_q  <= 1'b0;
      fifo_rd_en_q <= 1'b0;
    end else begin
      hold_add_q   <= hold_add_d;
      hold_data_q  <= hold_data_d;
      wr_pending_q <= wr_pending_d;
      regs_q       <= regs_d;
      wr_strobe_q  <= wr_strobe_d;
      rd_data_q    <= rd_data_d;
      underflow_q  <= underflow_d;
      fifo_rd_en_q <= fifo_rd_en_d;
    end
  end

  assign reg_q_o         = regs_q;
  assign wr_strobe_o     = wr_strobe_q;
  assign fifo_rd_en_o    = fifo_rd_en_q;
  assign bus.mc_data_out = rd_data_q;
  // pad enable follows the raw pins so the MCU sees data within its own access window
  assign bus.mc_data_oe  = ~bus.mc_ce & ~bus.mc_oe & bus.mc_we;

endmodule

// File: tb/tb_mc_bus_slave.sv
// Directed bench for mc_bus_slave: transaction-level expectation model with a
// per-cycle compare process, plus literal expectations for the scenario results.
module tb_mc_bus_slave;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NR = 8;
`ifdef MC_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*DW-1:0] reg_q_o;
  logic [NR-1:0]    wr_strobe_o;
  logic [DW-1:0]    fifo_rd_data_i;
  logic             fifo_empty_i;
  logic             fifo_rd_en_o;

  mc_bus_if #(.MC_DATA_WIDTH(DW), .MC_ADD_WIDTH(AW)) bus ();

  mc_bus_slave #(.MC_DATA_WIDTH(DW), .MC_ADD_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .reg_q_o        (reg_q_o),
    .wr_strobe_o    (wr_strobe_o),
    .fifo_rd_data_i (fifo_rd_data_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_en_o   (fifo_rd_en_o)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc      = 0;
  int            wr_due   = -1;
  int            pop_due  = -1;
  int            wr_addr  = 0;
  logic [DW-1:0] wr_data  = '0;
  logic [DW-1:0] exp_regs [NR];
  logic [NR-1:0] exp_strobe  = '0;
  logic          exp_pop     = 1'b0;
  logic          underflow_m = 1'b0;
  logic          rd_chk      = 1'b0;
  logic          exp_oe;
  logic [DW-1:0] exp_rd      = '0;
  logic [NR*DW-1:0] exp_flat;
  logic [NR*DW-1:0] lit_regs;
  logic [DW-1:0] fifo_q [$];
  int            strobe_cnt = 0;
  int            pop_cnt    = 0;
  logic [DW-1:0] m;

  task automatic chk(input string name, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (exp_regs[i]) exp_regs[i] = '0;
    wr_due      = -1;
    pop_due     = -1;
    exp_strobe  = '0;
    exp_pop     = 1'b0;
    underflow_m = 1'b0;
  endtask

  task automatic fifo_drive();
    fifo_empty_i   = (fifo_q.size() == 0);
    fifo_rd_data_i = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
  endtask

  // Model: a write lands 3 edges after we rises; a FIFO pop pulses 3 edges after oe falls.
  always @(posedge clk) begin
    cyc++;
    exp_strobe = '0;
    exp_pop    = 1'b0;
    if (cyc == wr_due) begin
      if (wr_addr < NR && wr_addr != 2 && wr_addr != NR - 1) begin
        exp_regs[wr_addr]   = wr_data;
        exp_strobe[wr_addr] = 1'b1;
      end
      wr_due = -1;
    end
    if (cyc == pop_due) begin
      exp_pop = 1'b1;
      pop_due = -1;
    end
  end

  // Compare every cycle, then let the FIFO environment react to a pop.
  always @(negedge clk) begin
    for (int k = 0; k < NR; k++) exp_flat[k*DW +: DW] = exp_regs[k];
    exp_oe = !bus.mc_ce && !bus.mc_oe && bus.mc_we;
    chk("reg_q", reg_q_o, exp_flat);
    chk("wr_strobe", wr_strobe_o, exp_strobe);
    chk("fifo_rd_en", fifo_rd_en_o, exp_pop);
    chk("mc_data_oe", bus.mc_data_oe, exp_oe);
    if (rd_chk) chk("mc_data", bus.mc_data_out, exp_rd);
    strobe_cnt += $countones(wr_strobe_o);
    if (fifo_rd_en_o) begin
      pop_cnt++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      fifo_drive();
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int low_cycles);
    step(1);
    bus.mc_add = a; bus.mc_data_in = d; bus.mc_ce = 1'b0;
    step(2);
    bus.mc_we = 1'b0;
    step(low_cycles);
    bus.mc_we = 1'b1;
    wr_due = cyc + 3; wr_addr = int'(a); wr_data = d;
    step(5);
    bus.mc_ce = 1'b1;
    step(3);
  endtask

  task automatic bus_read(input logic [AW-1:0] a, input int low_cycles, output logic [DW-1:0] mv);
    step(1);
    bus.mc_add = a; bus.mc_ce = 1'b0;
    step(3);
    bus.mc_oe = 1'b0;
    if (a == 6'd2) begin
      if (fifo_q.size() != 0) begin
        mv = fifo_q[0]; pop_due = cyc + 3;
      end else begin
        mv = 16'h0000; underflow_m = 1'b1;
      end
    end else if (a == 6'(NR - 1)) begin
      mv = {14'b0, underflow_m, fifo_q.size() == 0};
    end else if (a >= 6'(NR)) begin
      mv = 16'h0000;
    end else begin
      mv = READBACK ? exp_regs[a] : 16'h0000;
    end
    exp_rd = mv;
    step(4);
    rd_chk = 1'b1;
    step(low_cycles);
    rd_chk = 1'b0;
    bus.mc_oe = 1'b1;
    if (a == 6'(NR - 1)) underflow_m = 1'b0;
    step(4);
    bus.mc_ce = 1'b1;
    step(3);
  endtask

  initial begin
    bus.mc_ce = 1'b1; bus.mc_we = 1'b1; bus.mc_oe = 1'b1;
    bus.mc_add = '0; bus.mc_data_in = '0;
    rst_n = 1'b0;
    model_reset();
    fifo_drive();
    step(3);
    chk("rst_reg_q", reg_q_o, '0);
    chk("rst_strobe", wr_strobe_o, '0);
    chk("rst_pop", fifo_rd_en_o, 1'b0);
    chk("rst_data_oe", bus.mc_data_oe, 1'b0);
    chk("rst_rd_data", bus.mc_data_out, 16'h0000);
    rst_n = 1'b1;
    step(6);
    chk("post_rst_strobes", strobe_cnt, 0);

    bus_write(6'd0, 16'h00FF, 6);
    chk("w0_slot0", reg_q_o[15:0], 16'h00FF);
    chk("w0_others", reg_q_o[NR*DW-1:DW], '0);
    chk("w0_strobes", strobe_cnt, 1);

    bus_write(6'd1, 16'hBEEF, 4);
    bus_write(6'd6, 16'h0A0A, 3);
    bus_write(6'd7, 16'hFFFF, 3);
    chk("w_strobes", strobe_cnt, 3);
    bus_write(6'd2, 16'h1234, 4);
    bus_write(6'h3F, 16'h1234, 4);
    chk("ro_strobes", strobe_cnt, 3);
    lit_regs = {16'h0000, 16'h0A0A, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h00FF};
    chk("ro_reg_q", reg_q_o, lit_regs);

    fifo_q.push_back(16'hAAAA);
    fifo_q.push_back(16'h5555);
    fifo_drive();
    bus_read(6'd2, 5, m);
    chk("fifo_rd1", m, 16'hAAAA);
    bus_read(6'd2, 12, m);
    chk("fifo_rd2", m, 16'h5555);
    chk("fifo_pops", pop_cnt, 2);

    bus_read(6'd2, 4, m);
    chk("uflow_rd", m, 16'h0000);
    bus_read(6'd7, 4, m);
    chk("status1", m, 16'h0003);
    bus_read(6'd7, 4, m);
    chk("status2", m, 16'h0001);
    chk("uflow_pops", pop_cnt, 2);

    step(1);
    bus.mc_add = 6'd4; bus.mc_data_in = 16'h4444; bus.mc_ce = 1'b0;
    step(2);
    bus.mc_we = 1'b0;
    step(4);
    bus.mc_ce = 1'b1;
    step(4);
    bus.mc_we = 1'b1;
    step(6);
    chk("abort_slot4", reg_q_o[79:64], 16'h0000);
    chk("abort_strobes", strobe_cnt, 3);

    fifo_q.push_back(16'h1357);
    fifo_drive();
    step(1);
    bus.mc_add = 6'd2; bus.mc_data_in = 16'h2468; bus.mc_ce = 1'b0;
    step(2);
    bus.mc_we = 1'b0; bus.mc_oe = 1'b0;
    step(6);
    bus.mc_we = 1'b1;
    step(4);
    bus.mc_oe = 1'b1;
    step(4);
    bus.mc_ce = 1'b1;
    step(3);
    chk("simul_pops", pop_cnt, 2);
    bus_read(6'd2, 4, m);
    chk("simul_fifo_kept", m, 16'h1357);
    chk("simul_pops_after", pop_cnt, 3);

    step(1);
    bus.mc_add = 6'd3; bus.mc_data_in = 16'h0009; bus.mc_ce = 1'b0;
    step(2);
    bus.mc_we = 1'b0;
    step(3);
    rst_n = 1'b0;
    model_reset();
    step(2);
    bus.mc_we = 1'b1;
    step(2);
    bus.mc_ce = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(8);
    chk("rst_mid_slot3", reg_q_o[63:48], 16'h0000);
    chk("rst_mid_strobes", strobe_cnt, 3);

    bus_write(6'd5, 16'h0001, 4);
    chk("rb_slot5", reg_q_o[95:80], 16'h0001);
    bus_read(6'd5, 4, m);
    chk("rb_read5", m, READBACK ? 16'h0001 : 16'h0000);
    bus_read(6'h3F, 4, m);
    chk("oob_read", m, 16'h0000);
    chk("final_strobes", strobe_cnt, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mc_bus_slave.md
MC_BUS_SLAVE -- requirements
Module: mc_bus_slave

Interface
REQ-001 Parameter MC_DATA_WIDTH, default 16: MCU bus data width.
REQ-002 Parameter MC_ADD_WIDTH, default 6: MCU bus address width.
REQ-003 Parameter NUM_REGS, default 8: register slots at addresses 0..NUM_REGS-1.
REQ-004 clock  in  1: single clock; all sequential logic on its rising edge.
REQ-005 reset  in  1: asynchronous, active-low.
REQ-006 mc_ce  in  1: chip enable, active-low.
REQ-007 mc_we  in  1: write strobe, active-low.
REQ-008 mc_oe  in  1: output enable, active-low.
REQ-009 mc_add  in  MC_ADD_WIDTH: address.
REQ-010 mc_data  inout  MC_DATA_WIDTH: bidirectional data.
REQ-011 reg_q  out  NUM_REGS*MC_DATA_WIDTH: register contents, slot k at bits [k*W +: W].
REQ-012 wr_strobe  out  NUM_REGS: one-cycle pulse per committed write, one bit per slot.
REQ-013 fifo_rd_data  in  MC_DATA_WIDTH: FIFO head word.
REQ-014 fifo_empty  in  1: FIFO empty flag.
REQ-015 fifo_rd_en  out  1: one-cycle FIFO pop.

Function
REQ-016 mc_ce, mc_we and mc_oe SHALL each pass through a 2-flop synchronizer plus an edge-detect flop; all three SHALL reset to 1.
REQ-017 mc_add and mc_data SHALL be sampled into holding registers every clock while synced mc_we=0 and synced mc_ce=0.
REQ-018 A write SHALL commit on the synced rising edge of mc_we while synced mc_ce=0, using the held address and data; reg_q and wr_strobe update 3 clock edges after mc_we rises at the pin.
REQ-019 Address 2 is the FIFO read port and address NUM_REGS-1 is read-only status; writes to these, or to address >= NUM_REGS, SHALL be ignored with no wr_strobe.
REQ-020 mc_data SHALL be driven only when raw mc_ce=0, mc_oe=0 and mc_we=1, combinationally; otherwise it is high-Z.
REQ-021 The read data register SHALL track the address mux each clock while synced mc_oe=1.
REQ-022 The read data register SHALL freeze on the synced falling edge of mc_oe.
REQ-023 On the mc_oe falling edge at address 2 with fifo_empty=0, the register SHALL capture fifo_rd_data and pulse fifo_rd_en once.
REQ-024 On the mc_oe falling edge at address 2 with fifo_empty=1, the register SHALL return 0, issue no pop and set sticky underflow.
REQ-025 Status word: bit0 fifo_empty, bit1 underflow, other bits 0; underflow SHALL clear on the mc_oe rising edge of a status read.
REQ-026 Reads of address >= NUM_REGS SHALL return 0.
REQ-027 Exactly one fifo_rd_en SHALL be issued per mc_oe low pulse, however long the pulse.
REQ-028 If synced mc_ce rises while mc_we is low, the pending write SHALL be discarded.
REQ-029 Simultaneous synced mc_we and mc_oe low: the write SHALL proceed, and the read SHALL issue no pop.

Reset
REQ-030 While reset=0: reg_q=0, wr_strobe=0, fifo_rd_en=0, underflow=0, read data register=0, holding registers=0, synchronizers=1, mc_data high-Z.
REQ-031 On reset release, no write commit and no pop SHALL be issued before the first genuine mc_we or mc_oe edge.
REQ-032 Reset asserted mid-write SHALL discard that write.

Configuration
REQ-033 With MC_READBACK_EN defined, reads of writable slots SHALL return the reg_q contents.
REQ-034 Without MC_READBACK_EN, writable slots SHALL read 0; the FIFO port and status read normally.

Verification
REQ-035 Write 0x00FF to address 0 (we low 6 clocks) -> reg_q slot0=0x00FF and wr_strobe[0] single pulse 3 clocks after we rises; other slots unchanged.
REQ-036 FIFO holds 0xAAAA then 0x5555; two oe pulses at address 2 -> mc_data reads 0xAAAA then 0x5555; exactly two fifo_rd_en pulses.
REQ-037 Empty FIFO, oe pulse at address 2 -> read 0x0000 and no pop; status read -> 0x0003; second status read -> 0x0001.
REQ-038 Write 0x1234 to address 2 and to address 0x3F -> no wr_strobe, reg_q unchanged.
REQ-039 Reset pulled low during a write to address 3 with data 0x0009 -> slot3=0 after release, no strobe.
REQ-040 Write 0x0001 to address 5, then read address 5 -> 0x0001 with MC_READBACK_EN, 0x0000 without; mc_data high-Z whenever oe=1.
